// File: rtl/minmax_tracker_pkg.sv
// Shared definitions for the min/max frame tracker: FSM state encoding and
// default sample geometry.
package minmax_tracker_pkg;

  localparam int W_DEFAULT   = 5;
  localparam int LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : minmax_tracker_pkg

// File: rtl/minmax_tracker_if.sv
// Sample-in / result-out handshake bundle for minmax_tracker, plus the
// frame start pulse and busy indication.
interface minmax_tracker_if #(
  parameter int W   = 5,
  parameter int LEN = 8
);

  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_max;
  logic [W-1:0]            out_min;
  logic [$clog2(LEN)-1:0]  out_max_idx;
  logic                    busy;

  // Driver side: produces samples and consumes results.
  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_idx, busy
  );

  // Tracker side.
  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_idx, busy
  );

endinterface : minmax_tracker_if

// File: rtl/minmax_tracker_mag_cmp_w.sv
// Unsigned W-bit magnitude compare. Exactly one of eq/gt/lt is high for any
// operand pair; a is compared against b.
module mag_cmp_w #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o,
  output logic         gt_o,
  output logic         lt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);

endmodule : mag_cmp_w

// File: rtl/minmax_tracker.sv
// Frame-based running extremum tracker: accepts LEN unsigned samples, keeps
// the running max, min and first index of the max, and hands one registered
// result word to the consumer at end of frame.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int LEN = LEN_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  minmax_tracker_if.slave  bus
);

  localparam int IDX_W = $clog2(LEN);
  localparam int CNT_W = $clog2(LEN + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       max_q, max_d;
  logic [W-1:0]       min_q, min_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;

  logic eq_max, gt_max, lt_max;
  logic eq_min, gt_min, lt_min;
  logic accept;

  // in_data against the running maximum.
  mag_cmp_w #(.W(W)) u_cmp_max (
    .a_i  (bus.in_data),
    .b_i  (max_q),
    .eq_o (eq_max),
    .gt_o (gt_max),
    .lt_o (lt_max)
  );

  // in_data against the running minimum.
  mag_cmp_w #(.W(W)) u_cmp_min (
    .a_i  (bus.in_data),
    .b_i  (min_q),
    .eq_o (eq_min),
    .gt_o (gt_min),
    .lt_o (lt_min)
  );

  // Compare flags are one-hot; anything else means the comparator is broken.
  assert property (@(posedge clk) disable iff (reset)
                   $onehot({eq_max, gt_max, lt_max}) && $onehot({eq_min, gt_min, lt_min}));

  // Handshake and status are decoded from the state register only.
  assign bus.in_ready    = (state_q == FIRST) || (state_q == RUN);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_max     = max_q;
  assign bus.out_min     = min_q;
  assign bus.out_max_idx = idx_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Next-state and datapath update for the frame FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FIRST;
          cnt_d   = '0;
        end
      end
      FIRST: begin
        if (accept) begin
          max_d   = bus.in_data;
          min_d   = bus.in_data;
          idx_d   = '0;
          cnt_d   = CNT_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          // Strict compares: ties never move the extremes, so the earliest
          // index of the maximum is retained.
          if (gt_max) begin
            max_d = bus.in_data;
            idx_d = IDX_W'(cnt_q);
          end
          if (lt_min) begin
            min_d = bus.in_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEN - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
  end

  // State, counter and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule : minmax_tracker
